// File: rtl/pool_window_former.sv
// Streaming 2x2 stride-2 window former: buffers the even row, pairs it with the odd row.
// Window valid one cycle after its bottom-right pixel; a stalled output window blocks input.
module pool_window_former #(
  parameter int BITS  = 8,
  parameter int IMG_W = 28,
  parameter int IMG_H = 28
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [BITS*2-1:0]              in_data,
  output logic                           win_valid,
  input  logic                           win_ready,
  output logic [1:0][1:0][BITS*2-1:0]    win,
  output logic                           frame_done
);

  localparam int PW = BITS * 2;
  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  typedef enum logic {EVEN, ODD} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   col;
  logic [RW-1:0]   row;
  logic [PW-1:0]   line_buf [IMG_W];
  logic [PW-1:0]   hold;
  logic            acc;
  logic            col_last;
  logic            row_last;
  logic            win_load;
  logic [CW-1:0]   col_pair;

  assign in_ready = ~win_valid | win_ready;
  assign acc      = in_valid & in_ready;
  assign col_last = (col == CW'(IMG_W - 1));
  assign row_last = (row == RW'(IMG_H - 1));
  // IMG_W is even, so the left column of a pair is col with bit 0 cleared
  assign col_pair = col & ~CW'(1);

  always_comb begin
    state_nxt = state;
    win_load  = 1'b0;
    case (state)
      EVEN: begin
        if (acc && col_last) state_nxt = ODD;
      end
      ODD: begin
        if (acc && col[0]) win_load = 1'b1;
        if (acc && col_last) state_nxt = EVEN;
      end
      default: state_nxt = EVEN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= EVEN;
      col   <= '0;
      row   <= '0;
    end else begin
      state <= state_nxt;
      if (acc) begin
        if (col_last) begin
          col <= '0;
          row <= row_last ? '0 : row + RW'(1);
        end else begin
          col <= col + CW'(1);
        end
      end
    end
  end

  // Pixel storage needs no reset: a fresh frame always rewrites it before use
  always_ff @(posedge clk) begin
    if (acc && state == EVEN) line_buf[col] <= in_data;
    if (acc && state == ODD && !col[0]) hold <= in_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win        <= '0;
      win_valid  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= acc && (state == ODD) && col_last && row_last;
      if (win_load) begin
        win[0][0] <= line_buf[col_pair];
        win[0][1] <= line_buf[col];
        win[1][0] <= hold;
        win[1][1] <= in_data;
        win_valid <= 1'b1;
      end else if (win_ready) begin
        win_valid <= 1'b0;
      end
    end
  end

endmodule
